ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h00000000, instruction word driven on instr_id for a bubble.
REQ-002 SHALL have port CLK  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port imemaddr  input  32 (word_t)  current PC from program counter.
REQ-005 SHALL have port ihit  input  1  instruction memory returns valid data this cycle.
REQ-006 SHALL have port imemload  input  32 (word_t)  instruction data, valid when ihit=1.
REQ-007 SHALL have port stall_id  input  1  decode stage cannot accept a new instruction.
REQ-008 SHALL have port flush  input  1  branch/jump redirect resolved; PC loads new target.
REQ-009 SHALL have port iREN  output  1  instruction memory read enable.
REQ-010 SHALL have port pcEN  output  1  enable to program counter update.
REQ-011 SHALL have port instr_id  output  32 (word_t)  IF/ID instruction register.
REQ-012 SHALL have port npc_id  output  32 (word_t)  IF/ID next-PC register, imemaddr+4.
REQ-013 SHALL have port valid_id  output  1  IF/ID holds a real instruction.

Function
REQ-014 SHALL implement states FETCH and BUFFERED; BUFFERED exists only with IFETCH_SKID_EN.
REQ-015 FETCH: iREN=1; BUFFERED: iREN=0.
REQ-016 Event priority SHALL be flush > stall_id > ihit.
REQ-017 FETCH, flush=1: pcEN=1; next edge instr_id=NOP_INSTR, valid_id=0; ihit data discarded; stay FETCH.
REQ-018 FETCH, ihit=1, stall_id=0, flush=0: pcEN=1; next edge instr_id=imemload, npc_id=imemaddr+4 (mod 2^32, carry dropped), valid_id=1.
REQ-019 FETCH, ihit=0, no flush: pcEN=0; IF/ID holds if stall_id=1, else loads bubble (valid_id=0, instr_id=NOP_INSTR).
REQ-020 FETCH, ihit=1, stall_id=1, no flush: IF/ID holds; behaviour per Configuration.
REQ-021 BUFFERED, flush=1: skid entry dropped, pcEN=1, IF/ID loads bubble, next state FETCH.
REQ-022 BUFFERED, stall_id=0, no flush: skid contents moved to IF/ID with valid_id=1, pcEN=0, next state FETCH.
REQ-023 BUFFERED, stall_id=1, no flush: IF/ID and skid hold, pcEN=0.
REQ-024 pcEN, iREN SHALL be combinational from state and inputs; IF/ID outputs registered.
REQ-025 pcEN SHALL never be 1 for more than one cycle per accepted instruction or flush.

Reset
REQ-026 nRST=0 SHALL asynchronously force state=FETCH, instr_id=NOP_INSTR, npc_id=0, valid_id=0, skid empty.
REQ-027 While nRST=0, iREN=0 and pcEN=0; iREN=1 in first cycle after nRST deasserts.
REQ-028 Reset mid-stall or with skid full SHALL discard all held instructions.

Configuration
REQ-029 Macro IFETCH_SKID_EN SHALL select skid buffer.
REQ-030 Defined: FETCH with ihit=1, stall_id=1, no flush captures imemload and imemaddr+4 into one-entry skid, pcEN=1, next state BUFFERED.
REQ-031 Undefined: same case gives pcEN=0, nothing captured, stay FETCH; instruction re-fetched once stall clears.

Structure
REQ-032 word_t and enum ifetch_state_t {FETCH, BUFFERED} SHALL live in cpu_types_pkg.
REQ-033 Skid storage (instr, npc, full flag) SHALL be sub-module ifetch_skid, instantiated only under IFETCH_SKID_EN.

Verification
REQ-034 Reset release, imemaddr=0, ihit=1, imemload=32'h2001000A -> next edge instr_id=32'h2001000A, npc_id=4, valid_id=1, pcEN=1 that cycle.
REQ-035 ihit=1, stall_id=1 for 3 cycles, imemaddr=0x10 -> without skid: pcEN=0 all 3, IF/ID unchanged; with skid: pcEN=1 first cycle only, then BUFFERED, skid released on stall drop with npc_id=0x14.
REQ-036 flush=1 with ihit=1, stall_id=1 -> pcEN=1, next edge valid_id=0, instr_id=NOP_INSTR, state FETCH.
REQ-037 imemaddr=32'hFFFFFFFC accepted -> npc_id=0.
REQ-038 nRST asserted while BUFFERED -> immediately valid_id=0, state FETCH; post-reset first fetch is fresh.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch front end.
// Holds the machine word type and the fetch-stage state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        FETCH    = 1'b0,
        BUFFERED = 1'b1
    } ifetch_state_t;

    localparam word_t PC_STEP = 32'd4;

endpackage

// File: rtl/ifetch_skid.sv
// One-entry skid register for the fetch stage.
// Holds an instruction fetched while decode was stalled (IFETCH_SKID_EN builds).
module ifetch_skid
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        i_load,
    input  logic        i_clr,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_npc,
    output logic [31:0] o_instr,
    output logic [31:0] o_npc,
    output logic        o_full
);

    word_t r_instr;
    word_t r_npc;
    logic  r_full;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_instr <= '0;
            r_npc   <= '0;
            r_full  <= 1'b0;
        end else if (i_load) begin
            r_instr <= i_instr;
            r_npc   <= i_npc;
            r_full  <= 1'b1;
        end else if (i_clr) begin
            r_full  <= 1'b0;
        end
    end

    assign o_instr = r_instr;
    assign o_npc   = r_npc;
    assign o_full  = r_full;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage driving the IF/ID pipeline register.
// Define IFETCH_SKID_EN to add a one-entry skid buffer for fetches hit during a stall.
module ifetch_unit
    import cpu_types_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] imemaddr,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        stall_id,
    input  logic        flush,
    output logic        iREN,
    output logic        pcEN,
    output logic [31:0] instr_id,
    output logic [31:0] npc_id,
    output logic        valid_id
);

    ifetch_state_t r_state;
    ifetch_state_t w_next;

    word_t r_instr;
    word_t r_npc;
    logic  r_valid;

    word_t w_instr_d;
    word_t w_npc_d;
    logic  w_valid_d;
    logic  w_pc_en;
    word_t w_npc_fetch;

    assign w_npc_fetch = imemaddr + PC_STEP;

`ifdef IFETCH_SKID_EN
    logic  w_skid_ld;
    logic  w_skid_clr;
    word_t w_skid_instr;
    word_t w_skid_npc;
    logic  w_skid_full;

    ifetch_skid u_skid (
        .CLK     (CLK),
        .nRST    (nRST),
        .i_load  (w_skid_ld),
        .i_clr   (w_skid_clr),
        .i_instr (imemload),
        .i_npc   (w_npc_fetch),
        .o_instr (w_skid_instr),
        .o_npc   (w_skid_npc),
        .o_full  (w_skid_full)
    );
`endif

    always_comb begin
        w_next    = r_state;
        w_pc_en   = 1'b0;
        w_instr_d = r_instr;
        w_npc_d   = r_npc;
        w_valid_d = r_valid;
`ifdef IFETCH_SKID_EN
        w_skid_ld  = 1'b0;
        w_skid_clr = 1'b0;
`endif
        unique case (r_state)
            FETCH: begin
                if (flush) begin
                    w_pc_en   = 1'b1;
                    w_instr_d = NOP_INSTR;
                    w_valid_d = 1'b0;
                end else if (stall_id) begin
`ifdef IFETCH_SKID_EN
                    if (ihit) begin
                        w_pc_en   = 1'b1;
                        w_skid_ld = 1'b1;
                        w_next    = BUFFERED;
                    end
`endif
                end else if (ihit) begin
                    w_pc_en   = 1'b1;
                    w_instr_d = imemload;
                    w_npc_d   = w_npc_fetch;
                    w_valid_d = 1'b1;
                end else begin
                    w_instr_d = NOP_INSTR;
                    w_valid_d = 1'b0;
                end
            end
            BUFFERED: begin
`ifdef IFETCH_SKID_EN
                if (flush) begin
                    w_pc_en    = 1'b1;
                    w_skid_clr = 1'b1;
                    w_instr_d  = NOP_INSTR;
                    w_valid_d  = 1'b0;
                    w_next     = FETCH;
                end else if (!stall_id) begin
                    w_skid_clr = 1'b1;
                    w_instr_d  = w_skid_instr;
                    w_npc_d    = w_skid_npc;
                    w_valid_d  = w_skid_full;
                    w_next     = FETCH;
                end
`else
                w_next = FETCH;
`endif
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= FETCH;
            r_instr <= NOP_INSTR;
            r_npc   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_instr <= w_instr_d;
            r_npc   <= w_npc_d;
            r_valid <= w_valid_d;
        end
    end

    // Memory and PC handshakes are silenced while reset is held.
    assign iREN     = nRST && (r_state == FETCH);
    assign pcEN     = nRST && w_pc_en;
    assign instr_id = r_instr;
    assign npc_id   = r_npc;
    assign valid_id = r_valid;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: vector table plus stall/reset sequences.
// Expectations follow the build (IFETCH_SKID_EN defined or not).
module tb_ifetch_unit;

    localparam logic [31:0] NOP = 32'h00000000;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        stall_id;
    logic        flush;
    logic        iREN;
    logic        pcEN;
    logic [31:0] instr_id;
    logic [31:0] npc_id;
    logic        valid_id;

    int n_chk  = 0;
    int n_pass = 0;

    ifetch_unit #(.NOP_INSTR(NOP)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .stall_id (stall_id),
        .flush    (flush),
        .iREN     (iREN),
        .pcEN     (pcEN),
        .instr_id (instr_id),
        .npc_id   (npc_id),
        .valid_id (valid_id)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ihit;
        logic        stall;
        logic        flush;
        logic [31:0] addr;
        logic [31:0] load;
        logic        pc_en;
        logic        iren;
        logic [31:0] instr;
        logic [31:0] npc;
        logic        valid;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic h, input logic s, input logic f,
                         input logic [31:0] a, input logic [31:0] l);
        ihit = h; stall_id = s; flush = f; imemaddr = a; imemload = l;
    endtask

    task automatic step(input string tag, input logic ep, input logic er,
                        input logic [31:0] ei, input logic [31:0] en,
                        input logic ev);
        #1;
        chk({tag, ".pcEN"}, {31'b0, pcEN}, {31'b0, ep});
        chk({tag, ".iREN"}, {31'b0, iREN}, {31'b0, er});
        @(posedge CLK);
        #1;
        chk({tag, ".instr"}, instr_id, ei);
        chk({tag, ".npc"}, npc_id, en);
        chk({tag, ".valid"}, {31'b0, valid_id}, {31'b0, ev});
    endtask

    vec_t vt[8];

    initial begin
        vt[0] = '{1, 0, 0, 32'h0, 32'h2001000A, 1, 1, 32'h2001000A, 32'h4, 1};
        vt[1] = '{0, 0, 0, 32'h4, 32'hDEADBEEF, 0, 1, NOP, 32'h4, 0};
        vt[2] = '{1, 0, 0, 32'h4, 32'h11111111, 1, 1, 32'h11111111, 32'h8, 1};
        vt[3] = '{0, 1, 0, 32'h8, 32'hDEADBEEF, 0, 1, 32'h11111111, 32'h8, 1};
        vt[4] = '{1, 1, 1, 32'h8, 32'h22222222, 1, 1, NOP, 32'h8, 0};
        vt[5] = '{1, 0, 0, 32'hFFFFFFFC, 32'h33333333, 1, 1, 32'h33333333, 32'h0, 1};
        vt[6] = '{0, 0, 1, 32'h0, 32'h0, 1, 1, NOP, 32'h0, 0};
        vt[7] = '{1, 0, 0, 32'h20, 32'h44444444, 1, 1, 32'h44444444, 32'h24, 1};

        nRST = 1'b0;
        drive(1, 0, 0, 32'h0, 32'h2001000A);
        #2;
        chk("rst.iREN", {31'b0, iREN}, 32'h0);
        chk("rst.pcEN", {31'b0, pcEN}, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        chk("rst.instr", instr_id, NOP);
        chk("rst.npc", npc_id, 32'h0);
        chk("rst.valid", {31'b0, valid_id}, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;

        foreach (vt[i]) begin
            drive(vt[i].ihit, vt[i].stall, vt[i].flush, vt[i].addr, vt[i].load);
            step($sformatf("vec%0d", i), vt[i].pc_en, vt[i].iren,
                 vt[i].instr, vt[i].npc, vt[i].valid);
        end

        drive(1, 0, 0, 32'h0C, 32'hAAAAAAAA);
        step("pre_stall", 1, 1, 32'hAAAAAAAA, 32'h10, 1);
        for (int c = 0; c < 3; c++) begin
            drive(1, 1, 0, 32'h10, 32'hBBBBBBBB);
`ifdef IFETCH_SKID_EN
            step($sformatf("stall%0d", c), (c == 0), (c == 0),
                 32'hAAAAAAAA, 32'h10, 1);
`else
            step($sformatf("stall%0d", c), 0, 1, 32'hAAAAAAAA, 32'h10, 1);
`endif
        end
`ifdef IFETCH_SKID_EN
        drive(0, 0, 0, 32'h14, 32'hDEADBEEF);
        step("release", 0, 0, 32'hBBBBBBBB, 32'h14, 1);
`else
        drive(1, 0, 0, 32'h10, 32'hBBBBBBBB);
        step("release", 1, 1, 32'hBBBBBBBB, 32'h14, 1);
`endif

        drive(1, 1, 0, 32'h30, 32'hCCCCCCCC);
`ifdef IFETCH_SKID_EN
        step("hold_skid", 1, 1, 32'hBBBBBBBB, 32'h14, 1);
        drive(1, 1, 0, 32'h34, 32'hDDDDDDDD);
        #1;
        chk("buffered.iREN", {31'b0, iREN}, 32'h0);
`else
        step("hold_stall", 0, 1, 32'hBBBBBBBB, 32'h14, 1);
`endif
        #2;
        nRST = 1'b0;
        #1;
        chk("async.valid", {31'b0, valid_id}, 32'h0);
        chk("async.instr", instr_id, NOP);
        chk("async.npc", npc_id, 32'h0);
        chk("async.pcEN", {31'b0, pcEN}, 32'h0);
        @(negedge CLK);
        nRST = 1'b1;
        drive(0, 0, 0, 32'h40, 32'h0);
        #1;
        chk("post_rst.iREN", {31'b0, iREN}, 32'h1);
        @(posedge CLK);
        #1;
        chk("post_rst.valid", {31'b0, valid_id}, 32'h0);
        drive(1, 0, 0, 32'h40, 32'h12345678);
        step("fresh", 1, 1, 32'h12345678, 32'h44, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
